led_display_arbiter: RTL and testbench

Shares the 8-bit front-panel LED bank between an idle animation (the cylon sequence) and up to NREQ status requesters. Selection is fixed-priority with a minimum visible dwell time, so short status pulses remain readable by eye. Optional blinking is supported per requester. Sits between the cylon generator, the status/error sources and the LED output pins.

---
 rtl/led_arb_pkg.sv | 21 ++
 rtl/led_tick_gen.sv | 38 +++
 rtl/led_display_arbiter.sv | 177 +++++++++++++++++
 tb/tb_led_display_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED display arbiter.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Pattern driven onto the bank during the dark half of a blink.
    localparam logic [7:0] BLANK = 8'h00;

    // Widest request vector the priority helper handles.
    localparam int MAX_REQ = 32;

    // One-hot of the lowest set bit (index 0 = highest priority); zero if none.
    function automatic logic [MAX_REQ-1:0] lowest_set(input logic [MAX_REQ-1:0] vec);
        return vec & (~vec + MAX_REQ'(1));
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-clock tick every 2^MXPRE clocks,
// plus an 8-bit tick counter whose BLINK_BIT sets the blink phase.
module led_tick_gen #(
    parameter int MXPRE     = 21,
    parameter int BLINK_BIT = 2
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick,
    output logic blink_phase
);

    logic [MXPRE-1:0] pre_reg;
    logic [7:0]       tick_cnt_reg;

    // Tick fires on the all-ones count, the clock before the prescaler wraps.
    assign tick        = &pre_reg;
    assign blink_phase = tick_cnt_reg[BLINK_BIT];

    // Prescaler counts every clock and wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + MXPRE'(1);
        end
    end

    // Tick counter advances once per tick and wraps at 8 bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_reg <= 8'd0;
        end else if (tick) begin
            tick_cnt_reg <= tick_cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/led_display_arbiter.sv
// Fixed-priority owner of the front-panel LED bank with a minimum dwell per
// grant. The idle animation is shown whenever no requester holds the bank.
module led_display_arbiter
    import led_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int MXPRE      = 21,
    parameter int HOLD_TICKS = 8,
    parameter int BLINK_BIT  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        idle_pattern,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] pattern,
    input  logic [NREQ-1:0]   blink,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [7:0]        q
);

    localparam logic [7:0] HOLD = 8'(HOLD_TICKS);

    logic [1:0]      sync_reg;
    logic            run;
    logic            tick;
    logic            blink_phase;

    state_t          state_reg;
    state_t          state_next;

    logic [NREQ-1:0] grant_reg;
    logic [7:0]      lat_pat_reg;
    logic            lat_blk_reg;
    logic [7:0]      dwell_reg;
    logic [7:0]      q_reg;

    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] sel;
    logic [7:0]      sel_pat_part [NREQ];
    logic [NREQ-1:0] sel_blk_part;
    logic [7:0]      sel_pat;
    logic            sel_blk;

    logic            load;
    logic            refresh;
    logic            clear;
    logic            dec;
    logic [7:0]      gated;
    logic [7:0]      q_src;

    // Reset release is retimed so the FSM only starts after two clean clocks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign run = sync_reg[1];

    led_tick_gen #(
        .MXPRE     (MXPRE),
        .BLINK_BIT (BLINK_BIT)
    ) u_tick_gen (
        .clock       (clock),
        .reset_n     (reset_n),
        .tick        (tick),
        .blink_phase (blink_phase)
    );

    // Highest-priority (lowest-index) active request.
    assign pick = NREQ'(lowest_set(MAX_REQ'(req)));

    // Per-requester masking of pattern and blink by the one-hot selector.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
        assign sel_pat_part[gi] = sel[gi] ? pattern[8*gi +: 8] : BLANK;
        assign sel_blk_part[gi] = sel[gi] & blink[gi];
    end

    // OR-reduce the masked patterns into the selected one.
    always_comb begin
        sel_pat = BLANK;
        for (int i = 0; i < NREQ; i++) begin
            sel_pat = sel_pat | sel_pat_part[i];
        end
    end

    assign sel_blk = |sel_blk_part;

    // Latched pattern gated dark during the low blink phase.
    assign gated = (lat_blk_reg && !blink_phase) ? BLANK : lat_pat_reg;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: dwell expires on the last tick, CHECK then re-arbitrates.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (run && (|req)) state_next = SHOW;
            SHOW:    if ((dwell_reg == 8'd0) || (tick && (dwell_reg == 8'd1))) state_next = CHECK;
            CHECK:   state_next = (|req) ? SHOW : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode: grant loads, live refresh, dwell countdown, q source.
    always_comb begin
        load    = 1'b0;
        refresh = 1'b0;
        clear   = 1'b0;
        dec     = 1'b0;
        sel     = pick;
        q_src   = gated;
        case (state_reg)
            IDLE: begin
                load  = run && (|req);
                q_src = idle_pattern;
            end
            SHOW: begin
                sel     = grant_reg;
                refresh = |(req & grant_reg);
                dec     = tick && (dwell_reg != 8'd0);
            end
            CHECK: begin
                load  = |req;
                clear = ~(|req);
            end
            default: begin
                q_src = BLANK;
            end
        endcase
    end

    // Grant, latched pattern/blink, dwell and the LED output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_reg   <= '0;
            lat_pat_reg <= BLANK;
            lat_blk_reg <= 1'b0;
            dwell_reg   <= 8'd0;
            q_reg       <= BLANK;
        end else begin
            q_reg <= q_src;
            if (load) begin
                grant_reg   <= pick;
                lat_pat_reg <= sel_pat;
                lat_blk_reg <= sel_blk;
                dwell_reg   <= HOLD;
            end else begin
                if (clear) begin
                    grant_reg <= '0;
                end
                if (refresh) begin
                    lat_pat_reg <= sel_pat;
                    lat_blk_reg <= sel_blk;
                end
                if (dec) begin
                    dwell_reg <= dwell_reg - 8'd1;
                end
            end
        end
    end

    assign grant = grant_reg;
    assign busy  = (dwell_reg != 8'd0);
    assign q     = q_reg;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed plus randomized bench for led_display_arbiter against a
// behavioural reference model that tracks owner, dwell and tick time.
module tb_led_display_arbiter;

    localparam int NREQ = 4;
    localparam int MXPRE = 2;
    localparam int HOLD = 3;
    localparam int BB = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        idle_pattern;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] pattern;
    logic [NREQ-1:0]   blink;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        q;

    always #5 clock = ~clock;

    led_display_arbiter #(
        .NREQ       (NREQ),
        .MXPRE      (MXPRE),
        .HOLD_TICKS (HOLD),
        .BLINK_BIT  (BB)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .idle_pattern (idle_pattern),
        .req          (req),
        .pattern      (pattern),
        .blink        (blink),
        .grant        (grant),
        .busy         (busy),
        .q            (q)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: owner index (-1 none), whether re-arbitration is pending,
    // remaining dwell ticks, clocks and ticks elapsed since reset release.
    int         m_owner;
    bit         m_check;
    int         m_dwell;
    int         m_cyc;
    int         m_ticks;
    logic [7:0] m_pat;
    bit         m_blk;
    logic [7:0] m_q;

    function automatic int lowest(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_check = 0;
        m_dwell = 0;
        m_cyc   = 0;
        m_ticks = 0;
        m_pat   = 8'h00;
        m_blk   = 0;
        m_q     = 8'h00;
    endtask

    task automatic grab(input int w);
        m_owner = w;
        m_pat   = pattern[8*w +: 8];
        m_blk   = blink[w];
        m_dwell = HOLD;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        bit tick;
        bit phase;
        int w;
        tick  = (m_cyc % (1 << MXPRE)) == ((1 << MXPRE) - 1);
        phase = ((m_ticks >> BB) & 1) != 0;
        if (m_owner < 0) m_q = idle_pattern;
        else             m_q = (m_blk && !phase) ? 8'h00 : m_pat;

        if (m_owner < 0) begin
            w = lowest(req);
            if (m_cyc >= 2 && w >= 0) grab(w);
        end else if (!m_check) begin
            if (req[m_owner]) begin
                m_pat = pattern[8*m_owner +: 8];
                m_blk = blink[m_owner];
            end
            if (tick) begin
                m_dwell = m_dwell - 1;
                if (m_dwell == 0) m_check = 1;
            end
        end else begin
            m_check = 0;
            w = lowest(req);
            if (w < 0) m_owner = -1;
            else       grab(w);
        end

        if (tick) m_ticks = (m_ticks + 1) % 256;
        m_cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("grant", 32'(grant), 32'(eg));
        check("busy", 32'(busy), 32'(m_dwell != 0));
        check("q", 32'(q), 32'(m_q));
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            if (reset_n) model_edge();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        idle_pattern = 8'h01;
        req          = '0;
        blink        = '0;
        pattern      = '0;
        reset_n      = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_q", 32'(q), 32'h0);

        // Idle after release: q follows idle_pattern.
        reset_n = 1'b1;
        step(4);
        check("idle_q", 32'(q), 32'h01);

        // Requester 2 gets the bank, then requester 0 arrives mid-dwell.
        pattern[23:16] = 8'hA5;
        req = 4'b0100;
        step(1);
        check("grant2", 32'(grant), 32'h4);
        step(1);
        check("q_a5", 32'(q), 32'hA5);
        step(4);
        pattern[7:0] = 8'h5A;
        req = 4'b0101;
        step(20);
        req = '0;
        step(20);

        // One-clock pulse on requester 3 still holds the bank for the dwell.
        pattern[31:24] = 8'h3C;
        req = 4'b1000;
        step(1);
        req = '0;
        step(20);

        // Requester 1 blinking a full-on pattern.
        pattern[15:8] = 8'hFF;
        blink = 4'b0010;
        req = 4'b0010;
        step(80);

        // Asynchronous reset while the bank is owned.
        check("pre_rst_grant", 32'(grant), 32'h2);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_q", 32'(q), 32'h0);
        model_reset();
        step(2);
        reset_n = 1'b1;
        req = '0;
        idle_pattern = 8'h81;
        step(6);

        // Randomized traffic.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 7) == 0) blink = NREQ'($urandom);
            if ($urandom_range(0, 2) == 0) pattern = $urandom;
            if ($urandom_range(0, 3) == 0) idle_pattern = 8'($urandom);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
